// File: rtl/vedic_mul_sched.sv
// vedic_mul_sched: round-robin arbiter sharing one registered vedic multiplier core
// between NUM_REQ requesters, returning ID-tagged products over a valid/ready channel.
module vedic_mul_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_start,
    input  logic [2*WIDTH:0]         mul_product,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    input  logic                     rsp_ready,
    output logic                     busy
);
    localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] ptr, win, hi_win, lo_win;
    logic [WIDTH-1:0] win_a, win_b, hi_a, hi_b, lo_a, lo_b;
    logic hi_found, any_req;
    logic [CW-1:0] cnt;
    logic unused_msb;
    assign unused_msb = mul_product[2*WIDTH];
    assign any_req = |req_valid;
    // lowest requester above the pointer wins; otherwise wrap to the lowest set bit
    always_comb begin
        hi_found = 1'b0;
        hi_win = '0;
        lo_win = '0;
        hi_a = '0;
        hi_b = '0;
        lo_a = '0;
        lo_b = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_win = ID_W'(i);
                lo_a = req_a[i*WIDTH +: WIDTH];
                lo_b = req_b[i*WIDTH +: WIDTH];
                if (ID_W'(i) > ptr) begin
                    hi_found = 1'b1;
                    hi_win = ID_W'(i);
                    hi_a = req_a[i*WIDTH +: WIDTH];
                    hi_b = req_b[i*WIDTH +: WIDTH];
                end
            end
        end
    end
    assign win   = hi_found ? hi_win : lo_win;
    assign win_a = hi_found ? hi_a : lo_a;
    assign win_b = hi_found ? hi_b : lo_b;
    // gated by reset so the grant is also cleared while reset is held
    assign req_ready = (reset && state == IDLE && any_req) ? NUM_REQ'(1) << win : '0;
    assign mul_start = state == ISSUE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state == IDLE  ? (any_req ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (cnt == '0 ? RESP : WAIT) :
                                    (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= ID_W'(NUM_REQ - 1);
            cnt <= '0;
            mul_a <= '0;
            mul_b <= '0;
            rsp_id <= '0;
            rsp_product <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                ptr <= win;
                mul_a <= win_a;
                mul_b <= win_b;
            end
            if (state == ISSUE)
                cnt <= CW'(MUL_LAT - 1);
            if (state == WAIT && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == WAIT && cnt == '0) begin
                rsp_product <= mul_product[2*WIDTH-1:0];
                rsp_id <= ptr;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mul_sched.sv
// tb_vedic_mul_sched: table-driven single transactions plus arbitration, backpressure
// and reset sequences, with a scoreboard matching every response to its grant.
module tb_vedic_mul_sched;
    localparam int NR  = 4;
    localparam int W   = 2;
    localparam int LAT = 3;
    localparam int PW  = 2 * W + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*W-1:0] req_a = '0, req_b = '0;
    logic [NR-1:0] req_ready;
    logic [W-1:0] mul_a, mul_b;
    logic mul_start;
    logic [PW-1:0] mul_product;
    logic rsp_valid;
    logic [1:0] rsp_id;
    logic [2*W-1:0] rsp_product;
    logic rsp_ready = 1'b0;
    logic busy;

    vedic_mul_sched #(.NUM_REQ(NR), .WIDTH(W), .MUL_LAT(LAT), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // core model: product appears LAT cycles after mul_start for one cycle only
    logic [PW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mul_start ? PW'(mul_a) * PW'(mul_b) : '1;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_product = pipe[LAT-1];

    int n_cmp = 0, n_bad = 0;
    typedef struct { int id; int a; int b; int prod; } vec_t;
    typedef struct { int id; int prod; } exp_t;
    vec_t tbl [6];
    exp_t sb [$];
    int grants [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: push on grant handshake, pop and compare on response handshake
    always @(negedge clk) begin
        #2;
        if (!reset) sb.delete();
        else begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i])
                    sb.push_back('{i, int'(req_a[i*W +: W]) * int'(req_b[i*W +: W])});
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got id %0d product %0d expected no response", rsp_id, rsp_product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", rsp_id, e.id);
                    chk("sb_product", rsp_product, e.prod);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic wait_idle();
        int c;
        c = 0;
        #1;
        while (busy && c < 60) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("idle", busy, 0);
    endtask

    // called right after a negedge drive; releases granted bits unless sticky
    task automatic serve(input int n, input logic [NR-1:0] sticky);
        logic [NR-1:0] g;
        grants.delete();
        for (int c = 0; c < 400 && grants.size() < n; c++) begin
            #1;
            g = req_ready;
            for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
            @(negedge clk);
            req_valid = req_valid & ~(g & ~sticky);
        end
        req_valid = '0;
        chk("grant_count", grants.size(), n);
        wait_idle();
    endtask

    task automatic run_single(input vec_t v);
        @(negedge clk);
        req_valid = NR'(1) << v.id;
        req_a[v.id*W +: W] = W'(v.a);
        req_b[v.id*W +: W] = W'(v.b);
        rsp_ready = 1'b1;
        #1;
        chk("grant", req_ready, 1 << v.id);
        @(negedge clk);
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        #1;
        chk("start", mul_start, 1);
        chk("mul_a", mul_a, v.a);
        chk("mul_b", mul_b, v.b);
        chk("ready_issue", req_ready, 0);
        repeat (LAT) begin
            @(negedge clk);
            #1;
            chk("wait_start", mul_start, 0);
            chk("wait_rsp", rsp_valid, 0);
            chk("wait_mul_a", mul_a, v.a);
        end
        @(negedge clk);
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, v.id);
        chk("rsp_product", rsp_product, v.prod);
        @(negedge clk);
        #1;
        chk("busy_after", busy, 0);
    endtask

    initial begin
        tbl[0] = '{0, 3, 3, 9};
        tbl[1] = '{2, 0, 3, 0};
        tbl[2] = '{1, 2, 3, 6};
        tbl[3] = '{3, 3, 2, 6};
        tbl[4] = '{1, 1, 1, 1};
        tbl[5] = '{3, 0, 0, 0};

        req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        req_valid = '0;
        reset = 1'b1;

        foreach (tbl[i]) run_single(tbl[i]);

        // all four at once, pointer left at 3 by the table
        @(negedge clk);
        req_valid = 4'b1111;
        req_a = {2'd3, 2'd2, 2'd2, 2'd1};
        req_b = {2'd2, 2'd3, 2'd1, 2'd1};
        rsp_ready = 1'b1;
        serve(4, '0);
        for (int i = 0; i < 4; i++) chk("simul_order", grants[i], i);

        // fairness between 0 and 2 held high
        @(negedge clk);
        req_valid = 4'b0101;
        req_a = {2'd0, 2'd3, 2'd0, 2'd2};
        req_b = {2'd0, 2'd1, 2'd0, 2'd3};
        serve(8, 4'b0101);
        for (int i = 0; i < 8; i++) chk("fair_order", grants[i], (i % 2) ? 2 : 0);

        // backpressure with requester 1 pending
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a = {2'd0, 2'd0, 2'd3, 2'd3};
        req_b = {2'd0, 2'd0, 2'd3, 2'd2};
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        for (int c = 0; c < 20 && !rsp_valid; c++) begin
            @(negedge clk);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_product", rsp_product, 6);
            chk("bp_ready", req_ready, 0);
            chk("bp_start", mul_start, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_hs", req_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_grant1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        wait_idle();

        // reset during the second WAIT cycle drops the transaction
        @(negedge clk);
        req_valid = 4'b0100;
        req_a = {2'd1, 2'd3, 2'd0, 2'd2};
        req_b = {2'd3, 2'd3, 2'd0, 2'd2};
        #1;
        chk("rw_grant2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("rw_ready", req_ready, 0);
        chk("rw_mul_a", mul_a, 0);
        chk("rw_mul_b", mul_b, 0);
        chk("rw_start", mul_start, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_rsp_id", rsp_id, 0);
        chk("rw_rsp_product", rsp_product, 0);
        chk("rw_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1000;
        serve(1, '0);
        chk("rw_second_grant", grants[0], 3);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
